uart_tx_block_seq: RTL and testbench

Transmit sequencer that streams a multi-byte block, by default one 128-bit AES ciphertext or state, out through the byte-wide UART transmitter. It accepts a whole block with a valid/ready handshake and issues one `tx_start` per byte, MSB byte first. It waits for the transmitter's done flag between bytes and pulses `done` when the block has been sent. It sits between the AES core's result register and `UART_tx`, and is the only driver of the transmitter's `tx_start`/`d_in`.

---
 rtl/uart_txseq_pkg.sv | 15 +
 rtl/uart_txseq_xor.sv | 36 +++
 rtl/uart_tx_block_seq.sv | 114 +++++++++++
 tb/tb_uart_tx_block_seq.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_txseq_pkg.sv
// rtl/uart_txseq_pkg.sv - shared state type and constants for the UART block transmit sequencer
package uart_txseq_pkg;

  localparam int BYTE_W  = 8;
  localparam int GAP_LEN = 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    GAP,
    FIN
  } txseq_state_e;

endpackage

// File: rtl/uart_txseq_xor.sv
// rtl/uart_txseq_xor.sv - 8-bit XOR checksum accumulator with clear and fold enable
module uart_txseq_xor
  import uart_txseq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] din_i,
  output logic [BYTE_W-1:0] acc_o
);

  logic [BYTE_W-1:0] acc_q, acc_d;

  // clear takes priority over a fold in the same cycle
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ din_i;
    end
  end

  // accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/uart_tx_block_seq.sv
// rtl/uart_tx_block_seq.sv - streams a multi-byte block MSB byte first into the UART transmitter; UART_TXSEQ_CHECKSUM_EN appends an XOR checksum byte
module uart_tx_block_seq
  import uart_txseq_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     blk_valid,
  input  logic [BYTE_W*NBYTES-1:0] blk_data,
  output logic                     blk_ready,
  output logic                     tx_start,
  output logic [BYTE_W-1:0]        tx_byte,
  input  logic                     tx_done_flag,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(NBYTES + 2);
  localparam int SW = BYTE_W * NBYTES;
`ifdef UART_TXSEQ_CHECKSUM_EN
  localparam int TOTAL = NBYTES + 1;
`else
  localparam int TOTAL = NBYTES;
`endif

  txseq_state_e      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     shreg_q, shreg_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [BYTE_W-1:0] next_byte;

`ifdef UART_TXSEQ_CHECKSUM_EN
  logic              csum_clr;
  logic              csum_en;
  logic [BYTE_W-1:0] csum;

  // fold each data byte while it is on the wire; the checksum byte itself is not folded
  assign csum_clr = (state_q == IDLE) && blk_valid;
  assign csum_en  = (state_q == SEND) && (cnt_q < CW'(NBYTES));

  uart_txseq_xor u_xor (
    .clk   (clk),
    .reset (reset),
    .clr_i (csum_clr),
    .en_i  (csum_en),
    .din_i (byte_q),
    .acc_o (csum)
  );

  // once every data byte has gone, the shift register is empty and the checksum goes next
  assign next_byte = (cnt_q == CW'(NBYTES)) ? csum : shreg_q[SW-1 -: BYTE_W];
`else
  assign next_byte = shreg_q[SW-1 -: BYTE_W];
`endif

  // next-state logic: accept a block, then start/wait/gap for each byte, then pulse done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    byte_d  = byte_q;
    unique case (state_q)
      IDLE: begin
        if (blk_valid) begin
          shreg_d = blk_data;
          cnt_d   = '0;
          byte_d  = blk_data[SW-1 -: BYTE_W];
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done_flag) begin
          cnt_d   = cnt_q + CW'(1);
          shreg_d = shreg_q << BYTE_W;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q < CW'(TOTAL)) begin
          byte_d  = next_byte;
          state_d = SEND;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, counter, shift register and output byte registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      byte_q  <= byte_d;
    end
  end

  assign blk_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_start  = (state_q == SEND);
  assign done      = (state_q == FIN);
  assign tx_byte   = byte_q;

endmodule

// File: tb/tb_uart_tx_block_seq.sv
// tb/tb_uart_tx_block_seq.sv - self-checking bench for the UART block transmit sequencer
module tb_uart_tx_block_seq;

  localparam int NB = 16;
`ifdef UART_TXSEQ_CHECKSUM_EN
  localparam int TOT  = NB + 1;
  localparam int TOT1 = 2;
`else
  localparam int TOT  = NB;
  localparam int TOT1 = 1;
`endif
  localparam int NEVER = 32'h7fff_ffff;

  logic            clk = 1'b0;
  logic            reset;
  logic            blk_valid;
  logic [8*NB-1:0] blk_data;
  logic            blk_ready, tx_start, busy, done;
  logic [7:0]      tx_byte;
  logic            xmit_flag = 1'b0;
  logic            spur_flag = 1'b0;
  logic            tx_done_flag;

  logic            v1, fl1, rdy1, st1, busy1, done1;
  logic [7:0]      d1, byte1;

  int n_tests = 0;
  int n_fail  = 0;

  assign tx_done_flag = xmit_flag | spur_flag;

  always #5 clk = ~clk;

  uart_tx_block_seq #(.NBYTES(NB)) dut (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (blk_valid),
    .blk_data     (blk_data),
    .blk_ready    (blk_ready),
    .tx_start     (tx_start),
    .tx_byte      (tx_byte),
    .tx_done_flag (tx_done_flag),
    .busy         (busy),
    .done         (done)
  );

  uart_tx_block_seq #(.NBYTES(1)) dut1 (
    .clk          (clk),
    .reset        (reset),
    .blk_valid    (v1),
    .blk_data     (d1),
    .blk_ready    (rdy1),
    .tx_start     (st1),
    .tx_byte      (byte1),
    .tx_done_flag (fl1),
    .busy         (busy1),
    .done         (done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a timeline of edge numbers. E counts rising edges; a value
  // checked at a falling edge belongs to the cycle that began at edge E.
  int         E = 0;
  int         start_E = -1, done_E = -1, busy_start = -1, busy_end = -1, wait_from = 0;
  bit         armed = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_x;
  logic [7:0] mq[$];

  function automatic bit m_busy_at(input int t);
    return (busy_start >= 0) && (t >= busy_start) && (t <= busy_end);
  endfunction

  always @(posedge clk) begin
    E = E + 1;
    if (reset === 1'b1) begin
      start_E = -1; done_E = -1; busy_start = -1; busy_end = -1;
      armed = 1'b0; m_byte = 8'h00; mq.delete();
    end else begin
      if (armed && E >= wait_from && tx_done_flag === 1'b1) begin
        armed = 1'b0;
        if (mq.size() == 0) begin
          done_E   = E + 1;
          busy_end = E + 1;
        end else begin
          start_E = E + 1;
        end
      end else if (!m_busy_at(E - 1) && blk_valid === 1'b1) begin
        mq.delete();
        m_x = 8'h00;
        for (int i = 0; i < NB; i++) begin
          mq.push_back(blk_data[8*(NB-1-i) +: 8]);
          m_x = m_x ^ blk_data[8*(NB-1-i) +: 8];
        end
`ifdef UART_TXSEQ_CHECKSUM_EN
        mq.push_back(m_x);
`endif
        busy_start = E;
        busy_end   = NEVER;
        start_E    = E;
        done_E     = -1;
      end
      if (start_E == E) begin
        m_byte    = mq.pop_front();
        armed     = 1'b1;
        wait_from = E + 2;
      end
    end
  end

  // per-cycle comparison against the model, plus a log of what was sent
  int         done_cnt = 0, done_seen_E = -1, start_cnt = 0, st1_cnt = 0;
  bit         exp_busy;
  logic [7:0] log_q[$];

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      exp_busy = m_busy_at(E);
      chk("busy", busy, exp_busy);
      chk("blk_ready", blk_ready, !exp_busy);
      chk("tx_start", tx_start, E == start_E);
      chk("done", done, E == done_E);
      chk("tx_byte", tx_byte, m_byte);
      if (tx_start === 1'b1) begin
        log_q.push_back(tx_byte);
        start_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_seen_E = E;
      end
      if (st1 === 1'b1) st1_cnt++;
    end
  end

  // transmitter stand-in: answers each start with a done flag xdelay cycles later
  int xdelay = 20, pend_E = -1, flags_sent = 0, last_flag_edge = -1;
  bit hold2 = 1'b0;

  always begin
    @(negedge clk);
    if (tx_start === 1'b1) pend_E = E + xdelay;
    #1;
    if (E == pend_E) begin
      xmit_flag = 1'b1;
      flags_sent++;
      last_flag_edge = E + 1;
    end else if (hold2 && E == pend_E + 1) begin
      xmit_flag = 1'b1;
    end else begin
      xmit_flag = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [8*NB-1:0] seq_block(input logic [7:0] first);
    logic [8*NB-1:0] r;
    for (int i = 0; i < NB; i++) r[8*(NB-1-i) +: 8] = first + 8'(i);
    return r;
  endfunction

  function automatic logic [8*NB-1:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_block(input logic [8*NB-1:0] dat);
    int n;
    n = 0;
    while (blk_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ready_timeout", n < 200, 1);
    blk_valid = 1'b1;
    blk_data  = dat;
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int c0, n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < limit) begin
      tick();
      n++;
    end
    chk(name, done_cnt != c0, 1);
  endtask

  task automatic check_log(input string name, input logic [8*NB-1:0] dat);
    chk({name, "_count"}, log_q.size(), TOT);
    for (int i = 0; i < NB; i++) begin
      if (log_q.size() > i) chk({name, "_byte"}, log_q[i], dat[8*(NB-1-i) +: 8]);
    end
`ifdef UART_TXSEQ_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < NB; i++) x = x ^ dat[8*(NB-1-i) +: 8];
      if (log_q.size() > NB) chk({name, "_csum"}, log_q[NB], x);
    end
`endif
  endtask

  logic [8*NB-1:0] d;
  int              n, c;

  initial begin
    reset = 1'b1; blk_valid = 1'b0; blk_data = '0;
    v1 = 1'b0; d1 = 8'h00; fl1 = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst1_ready", rdy1, 1);
    reset = 1'b0;
    tick();

    // nominal block 00..0F, 20-cycle transmitter
    xdelay = 20;
    log_q.delete();
    send_block(seq_block(8'h00));
    wait_done("nominal_done", 2000);
    check_log("nominal", seq_block(8'h00));
    chk("nominal_first", log_q[0], 8'h00);
    chk("nominal_16th", log_q[15], 8'h0F);
    chk("nominal_done_lat", done_seen_E - last_flag_edge, 1);

    // block 01..10: final byte is 0x10 with or without the checksum byte
    tick();
    log_q.delete();
    send_block(seq_block(8'h01));
    wait_done("csum_done", 2000);
    chk("csum_count", log_q.size(), TOT);
    chk("csum_last", log_q[TOT-1], 8'h10);

    // offer while busy during byte 3
    xdelay = 4;
    log_q.delete();
    d = rand_block();
    send_block(d);
    n = 0;
    while (log_q.size() < 3 && n < 200) begin tick(); n++; end
    chk("busy_offer_wait", n < 200, 1);
    blk_valid = 1'b1;
    blk_data  = '1;
    repeat (6) tick();
    blk_valid = 1'b0;
    wait_done("busy_offer_done", 2000);
    check_log("busy_offer", d);

    // spurious done flag in IDLE
    tick(); tick();
    c = start_cnt;
    spur_flag = 1'b1;
    tick();
    spur_flag = 1'b0;
    repeat (3) tick();
    chk("spur_idle_nostart", start_cnt, c);
    chk("spur_idle_busy", busy, 0);

    // done flag held into every GAP cycle
    hold2 = 1'b1;
    log_q.delete();
    d = seq_block(8'h30);
    send_block(d);
    wait_done("gap_flag_done", 2000);
    hold2 = 1'b0;
    check_log("gap_flag", d);

    // reset after the 5th byte's done
    xdelay = 3;
    log_q.delete();
    c = flags_sent;
    send_block(rand_block());
    n = 0;
    while (flags_sent - c < 5 && n < 300) begin tick(); n++; end
    chk("midrst_wait", n < 300, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", blk_ready, 1);
    chk("midrst_start", tx_start, 0);
    chk("midrst_byte", tx_byte, 8'h00);
    repeat (2) tick();
    pend_E = -1;
    reset  = 1'b0;
    tick();
    log_q.delete();
    d = {8'hAA, rand_block()};
    d[8*NB-1 -: 8] = 8'hAA;
    send_block(d);
    wait_done("restart_done", 2000);
    chk("restart_first", log_q[0], 8'hAA);
    check_log("restart", d);

    // randomized blocks with random delays, spurious flags and offers while busy
    for (int b = 0; b < 20; b++) begin
      xdelay = $urandom_range(1, 6);
      d = rand_block();
      log_q.delete();
      send_block(d);
      c = done_cnt;
      n = 0;
      while (done_cnt == c && n < 2000) begin
        spur_flag = ($urandom_range(0, 19) == 0);
        blk_valid = ($urandom_range(0, 7) == 0);
        blk_data  = rand_block();
        tick();
        n++;
      end
      spur_flag = 1'b0;
      blk_valid = 1'b0;
      chk("rand_done", done_cnt != c, 1);
      check_log("rand", d);
    end

    // single-byte block on the NBYTES=1 instance
    tick();
    v1 = 1'b1;
    d1 = 8'h5A;
    tick();
    v1 = 1'b0;
    chk("one_start", st1, 1);
    chk("one_byte", byte1, 8'h5A);
    chk("one_busy", busy1, 1);
    repeat (3) tick();
    fl1 = 1'b1;
    tick();
    fl1 = 1'b0;
    chk("one_gap_done", done1, 0);
    chk("one_gap_start", st1, 0);
`ifdef UART_TXSEQ_CHECKSUM_EN
    tick();
    chk("one_csum_start", st1, 1);
    chk("one_csum_byte", byte1, 8'h5A);
    repeat (3) tick();
    fl1 = 1'b1;
    tick();
    fl1 = 1'b0;
`endif
    tick();
    chk("one_done", done1, 1);
    tick();
    chk("one_ready", rdy1, 1);
    chk("one_done_low", done1, 0);
    fl1 = 1'b1;
    tick();
    fl1 = 1'b0;
    repeat (3) tick();
    chk("one_start_count", st1_cnt, TOT1);
    chk("one_idle_busy", busy1, 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
